sram64kb_ctrl: RTL and testbench

//  Initiator side of the 64-bank SRAM64KB array (64 x SRAM1RW1024x8).

---
 rtl/sram64kb_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_sram64kb_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram64kb_ctrl.sv
// sram64kb_ctrl: initiator for the 64-bank SRAM1RW1024x8 array.
// Takes one byte request at a time, sequences SETUP/STROBE/CAPTURE on the
// SRAM pins and returns the read data or write ack on a valid/ready port.
// Optional feature macro: MEMCTRL_BANKCHK_EN. When defined, banks >= NUM_BANKS
// get an immediate error response with no SRAM activity.
module sram64kb_ctrl #(
  parameter int unsigned NUM_BANKS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [9:0]  mem_addr,
  output logic        mem_ce,
  output logic        mem_web,
  output logic [63:0] mem_oeb,
  output logic [63:0] mem_csb,
  output logic [7:0]  mem_idata,
  input  logic [7:0]  odata
);

  localparam int unsigned BANK_W   = 6;
  localparam int unsigned BANK_MAX = 64;

`ifdef MEMCTRL_BANKCHK_EN
  localparam logic BANKCHK = 1'b1;
`else
  localparam logic BANKCHK = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic        r_we;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;

  logic        cur_we;
  logic [15:0] cur_addr;
  logic [7:0]  cur_wdata;
  logic [BANK_W-1:0] bank;
  logic        bank_ok;
  logic [BANK_MAX-1:0] sel;

  logic [9:0]  addr_nxt;
  logic        ce_nxt;
  logic        web_nxt;
  logic [63:0] oeb_nxt;
  logic [63:0] csb_nxt;
  logic [7:0]  idata_nxt;
  logic        rv_nxt;
  logic [7:0]  rd_nxt;
  logic        err_nxt;

  assign req_ready = (state == S_IDLE);

  // Request fields: live inputs while accepting, latched copy afterwards
  always_comb begin
    cur_we    = r_we;
    cur_addr  = r_addr;
    cur_wdata = r_wdata;
    if (state == S_IDLE) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end
    bank    = cur_addr[15:10];
    bank_ok = (7'(bank) < 7'(NUM_BANKS));
    sel     = bank_ok ? (BANK_MAX'(1) << bank) : '0;
  end

  // Next-state and next registered output values
  always_comb begin
    state_nxt = state;
    addr_nxt  = mem_addr;
    ce_nxt    = mem_ce;
    web_nxt   = mem_web;
    oeb_nxt   = mem_oeb;
    csb_nxt   = mem_csb;
    idata_nxt = mem_idata;
    rv_nxt    = rsp_valid;
    rd_nxt    = rsp_rdata;
    err_nxt   = rsp_err;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (BANKCHK && !bank_ok) begin
            state_nxt = S_RESP;
            rv_nxt    = 1'b1;
            rd_nxt    = 8'h00;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = S_SETUP;
            addr_nxt  = cur_addr[9:0];
            idata_nxt = cur_wdata;
            web_nxt   = ~cur_we;
            csb_nxt   = ~sel;
            oeb_nxt   = '1;
            ce_nxt    = 1'b0;
            err_nxt   = 1'b0;
          end
        end
      end
      S_SETUP: begin
        state_nxt = S_STROBE;
        ce_nxt    = 1'b1;
      end
      S_STROBE: begin
        if (r_we) begin
          state_nxt = S_RESP;
          ce_nxt    = 1'b0;
          csb_nxt   = '1;
          oeb_nxt   = '1;
          web_nxt   = 1'b1;
          rv_nxt    = 1'b1;
          rd_nxt    = 8'h00;
          err_nxt   = 1'b0;
        end else begin
          state_nxt = S_CAPTURE;
          oeb_nxt   = ~sel;
        end
      end
      S_CAPTURE: begin
        state_nxt = S_RESP;
        ce_nxt    = 1'b0;
        csb_nxt   = '1;
        oeb_nxt   = '1;
        web_nxt   = 1'b1;
        rv_nxt    = 1'b1;
        rd_nxt    = odata;
        err_nxt   = 1'b0;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_nxt = S_IDLE;
          rv_nxt    = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, request latch and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      mem_addr  <= '0;
      mem_ce    <= 1'b0;
      mem_web   <= 1'b1;
      mem_oeb   <= '1;
      mem_csb   <= '1;
      mem_idata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      if (state == S_IDLE && req_valid) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      mem_addr  <= addr_nxt;
      mem_ce    <= ce_nxt;
      mem_web   <= web_nxt;
      mem_oeb   <= oeb_nxt;
      mem_csb   <= csb_nxt;
      mem_idata <= idata_nxt;
      rsp_valid <= rv_nxt;
      rsp_rdata <= rd_nxt;
      rsp_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_sram64kb_ctrl.sv
// Bench for sram64kb_ctrl: behavioural SRAM array model plus a flat
// byte-memory scoreboard; a second instance with NUM_BANKS=32 covers
// out-of-range banks.
module tb_sram64kb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [7:0]  rsp_rdata;
  logic [9:0]  mem_addr;
  logic        mem_ce, mem_web;
  logic [63:0] mem_oeb, mem_csb;
  logic [7:0]  mem_idata, odata;

  logic        req_valid32, req_ready32, req_we32;
  logic [15:0] req_addr32;
  logic [7:0]  req_wdata32;
  logic        rsp_valid32, rsp_ready32, rsp_err32;
  logic [7:0]  rsp_rdata32;
  logic [9:0]  mem_addr32;
  logic        mem_ce32, mem_web32;
  logic [63:0] mem_oeb32, mem_csb32;
  logic [7:0]  mem_idata32, odata32;

  logic [7:0] sram    [0:65535] = '{default: 8'h00};
  logic [7:0] exp_mem [0:65535] = '{default: 8'h00};

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram64kb_ctrl #(.NUM_BANKS(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_ce(mem_ce), .mem_web(mem_web),
    .mem_oeb(mem_oeb), .mem_csb(mem_csb), .mem_idata(mem_idata), .odata(odata)
  );

  sram64kb_ctrl #(.NUM_BANKS(32)) dut32 (
    .clk(clk), .rst(rst), .req_valid(req_valid32), .req_ready(req_ready32),
    .req_we(req_we32), .req_addr(req_addr32), .req_wdata(req_wdata32),
    .rsp_valid(rsp_valid32), .rsp_ready(rsp_ready32), .rsp_rdata(rsp_rdata32),
    .rsp_err(rsp_err32), .mem_addr(mem_addr32), .mem_ce(mem_ce32), .mem_web(mem_web32),
    .mem_oeb(mem_oeb32), .mem_csb(mem_csb32), .mem_idata(mem_idata32), .odata(odata32)
  );

  // SRAM array: write on CE rising edge into the selected bank
  always @(posedge mem_ce) begin
    for (int b = 0; b < 64; b++)
      if (!mem_csb[b] && !mem_web) sram[{6'(b), mem_addr}] = mem_idata;
  end

  // OR-merged read data of selected, output-enabled banks
  always_comb begin
    odata = 8'h00;
    for (int b = 0; b < 64; b++)
      if (!mem_csb[b] && !mem_oeb[b]) odata = odata | sram[{6'(b), mem_addr}];
  end

  always_comb begin
    odata32 = 8'h00;
    for (int b = 0; b < 64; b++)
      if (!mem_csb32[b] && !mem_oeb32[b]) odata32 = odata32 | sram[{6'(b), mem_addr32}];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request into dut and observes the response cycle
  task automatic run_txn(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                         output int lat, output logic [7:0] rd, output logic er,
                         output logic [63:0] csb1, output logic web1,
                         output logic [63:0] oeb3, output int multi);
    multi = 0; csb1 = '1; web1 = 1'b1; oeb3 = '1;
    req_we = we; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 16) begin
      if (lat == 1) begin csb1 = mem_csb; web1 = mem_web; end
      if (lat == 3) oeb3 = mem_oeb;
      if ($countones(~mem_csb) > 1 || $countones(~mem_oeb) > 1) multi++;
      step();
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    if (rsp_ready) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    req_valid32 = 1'b0; req_we32 = 1'b0; req_addr32 = '0; req_wdata32 = '0;
    rsp_ready32 = 1'b1;
    step(); step();
    rst = 1'b0;
    checks++; if (mem_csb !== '1)   begin errors++; $display("FAIL reset_csb got %h exp all ones", mem_csb); end
    checks++; if (mem_oeb !== '1)   begin errors++; $display("FAIL reset_oeb got %h exp all ones", mem_oeb); end
    checks++; if ({mem_web, mem_ce} !== 2'b10) begin errors++; $display("FAIL reset_web_ce got %b exp 10", {mem_web, mem_ce}); end
    checks++; if ({mem_addr, mem_idata} !== 18'h0) begin errors++; $display("FAIL reset_addr_idata got %h exp 0", {mem_addr, mem_idata}); end
    checks++; if ({rsp_valid, rsp_rdata, rsp_err} !== 10'h0) begin errors++; $display("FAIL reset_rsp got %h exp 0", {rsp_valid, rsp_rdata, rsp_err}); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    checks++; if ({req_ready32, rsp_valid32, mem_csb32} !== {2'b10, 64'hFFFF_FFFF_FFFF_FFFF}) begin errors++; $display("FAIL reset_dut32 got %b %b %h", req_ready32, rsp_valid32, mem_csb32); end
  endtask

  task automatic test_basic();
    int lat, multi; logic [7:0] rd; logic er, web1; logic [63:0] csb1, oeb3;
    run_txn(1'b1, 16'h0403, 8'hA5, lat, rd, er, csb1, web1, oeb3, multi);
    exp_mem[16'h0403] = 8'hA5;
    checks++; if (lat != 3) begin errors++; $display("FAIL basic_wr_lat got %0d exp 3", lat); end
    checks++; if (csb1 !== ~(64'd1 << 1)) begin errors++; $display("FAIL basic_wr_csb got %h exp %h", csb1, ~(64'd1 << 1)); end
    checks++; if (web1 !== 1'b0) begin errors++; $display("FAIL basic_wr_web got %b exp 0", web1); end
    checks++; if ({rd, er} !== 9'h0) begin errors++; $display("FAIL basic_wr_rsp got %h exp 0", {rd, er}); end
    run_txn(1'b0, 16'h0403, 8'h00, lat, rd, er, csb1, web1, oeb3, multi);
    checks++; if (lat != 4) begin errors++; $display("FAIL basic_rd_lat got %0d exp 4", lat); end
    checks++; if (oeb3 !== ~(64'd1 << 1)) begin errors++; $display("FAIL basic_rd_oeb got %h exp %h", oeb3, ~(64'd1 << 1)); end
    checks++; if (rd !== exp_mem[16'h0403]) begin errors++; $display("FAIL basic_rd_data got %h exp %h", rd, exp_mem[16'h0403]); end
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL basic_post_hs got %b exp 01", {rsp_valid, req_ready}); end
  endtask

  task automatic test_corners();
    int lat, multi; logic [7:0] rd; logic er, web1; logic [63:0] csb1, oeb3;
    run_txn(1'b1, 16'hFFFF, 8'h3C, lat, rd, er, csb1, web1, oeb3, multi);
    exp_mem[16'hFFFF] = 8'h3C;
    checks++; if (csb1 !== ~(64'd1 << 63)) begin errors++; $display("FAIL corner_wr_csb got %h exp %h", csb1, ~(64'd1 << 63)); end
    run_txn(1'b0, 16'hFFFF, 8'h00, lat, rd, er, csb1, web1, oeb3, multi);
    checks++; if (rd !== exp_mem[16'hFFFF]) begin errors++; $display("FAIL corner_rd_ffff got %h exp %h", rd, exp_mem[16'hFFFF]); end
    run_txn(1'b0, 16'h0000, 8'h00, lat, rd, er, csb1, web1, oeb3, multi);
    checks++; if (rd !== exp_mem[16'h0000]) begin errors++; $display("FAIL corner_rd_0000 got %h exp %h", rd, exp_mem[16'h0000]); end
    checks++; if (oeb3 !== ~64'd1) begin errors++; $display("FAIL corner_rd_oeb0 got %h exp %h", oeb3, ~64'd1); end
  endtask

  task automatic test_random();
    int lat, multi, gap; logic [7:0] rd, ex; logic er, web1, we; logic [63:0] csb1, oeb3;
    logic [15:0] a; logic [7:0] d;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      // Reuse a small address pool half the time so reads hit written bytes
      a  = (i % 2 == 0) ? 16'($urandom) : {6'($urandom_range(0, 3)) << 4, 10'($urandom_range(0, 3))};
      d  = 8'($urandom);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step();
      ex = we ? 8'h00 : exp_mem[a];
      run_txn(we, a, d, lat, rd, er, csb1, web1, oeb3, multi);
      if (we) exp_mem[a] = d;
      checks++; if (lat != (we ? 3 : 4)) begin errors++; $display("FAIL rand_lat[%0d] got %0d exp %0d", i, lat, we ? 3 : 4); end
      checks++; if ({rd, er} !== {ex, 1'b0}) begin errors++; $display("FAIL rand_rsp[%0d] addr %h got %h/%b exp %h/0", i, a, rd, er, ex); end
      checks++; if ({csb1, web1} !== {~(64'd1 << a[15:10]), ~we}) begin errors++; $display("FAIL rand_setup[%0d] got %h/%b exp %h/%b", i, csb1, web1, ~(64'd1 << a[15:10]), ~we); end
      checks++; if (multi != 0) begin errors++; $display("FAIL rand_onehot[%0d] got %0d exp 0", i, multi); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, multi, c0; logic [7:0] rd; logic er, web1, we; logic [63:0] csb1, oeb3;
    for (int i = 0; i < 6; i++) begin
      we = 1'(i % 2);
      c0 = cyc;
      run_txn(we, 16'h1234, 8'(i), lat, rd, er, csb1, web1, oeb3, multi);
      if (we) exp_mem[16'h1234] = 8'(i);
      checks++; if (cyc - c0 != (we ? 4 : 5)) begin errors++; $display("FAIL b2b_period[%0d] got %0d exp %0d", i, cyc - c0, we ? 4 : 5); end
    end
  endtask

  task automatic test_backpressure();
    int lat, multi; logic [7:0] rd; logic er, web1; logic [63:0] csb1, oeb3;
    rsp_ready = 1'b0;
    run_txn(1'b0, 16'h0403, 8'h00, lat, rd, er, csb1, web1, oeb3, multi);
    checks++; if (lat != 4) begin errors++; $display("FAIL bp_lat got %0d exp 4", lat); end
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0403; req_wdata = 8'hFF; end
      if (i == 2) req_valid = 1'b0;
      step();
      checks++;
      if ({rsp_valid, rsp_rdata, req_ready, mem_csb} !== {1'b1, exp_mem[16'h0403], 1'b0, 64'hFFFF_FFFF_FFFF_FFFF}) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h rr=%b csb=%h exp 1/%h/0/all ones", i, rsp_valid, rsp_rdata, req_ready, mem_csb, exp_mem[16'h0403]);
      end
    end
    rsp_ready = 1'b1;
    step();
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL bp_release got %b exp 01", {rsp_valid, req_ready}); end
    run_txn(1'b0, 16'h0403, 8'h00, lat, rd, er, csb1, web1, oeb3, multi);
    checks++; if (rd !== exp_mem[16'h0403]) begin errors++; $display("FAIL bp_ignored_wr got %h exp %h", rd, exp_mem[16'h0403]); end
  endtask

  task automatic test_reset_mid();
    int lat, multi, seen; logic [7:0] rd; logic er, web1; logic [63:0] csb1, oeb3;
    req_we = 1'b0; req_addr = 16'h0403; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    checks++; if (mem_ce !== 1'b1) begin errors++; $display("FAIL rstmid_strobe_ce got %b exp 1", mem_ce); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if ({mem_csb, mem_oeb, mem_ce, rsp_valid, req_ready} !== {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 3'b001}) begin
      errors++; $display("FAIL rstmid_state got csb=%h oeb=%h ce=%b v=%b rr=%b", mem_csb, mem_oeb, mem_ce, rsp_valid, req_ready);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin step(); if (rsp_valid) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_no_rsp got %0d exp 0", seen); end
    run_txn(1'b0, 16'hFFFF, 8'h00, lat, rd, er, csb1, web1, oeb3, multi);
    checks++; if ({lat, rd} !== {32'd4, exp_mem[16'hFFFF]}) begin errors++; $display("FAIL rstmid_after got %0d/%h exp 4/%h", lat, rd, exp_mem[16'hFFFF]); end
  endtask

  task automatic test_out_of_range();
    int lat, multi, csb_low, exp_lat; logic [7:0] rd; logic er, web1, exp_err; logic [63:0] csb1, oeb3;
    // Put data in physical bank 32 so a missing deselect would show
    run_txn(1'b1, 16'h8000, 8'h77, lat, rd, er, csb1, web1, oeb3, multi);
    exp_mem[16'h8000] = 8'h77;
`ifdef MEMCTRL_BANKCHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    for (int k = 0; k < 2; k++) begin
      exp_lat = exp_err ? 1 : (k == 0 ? 4 : 3);
      req_we32 = 1'(k); req_addr32 = 16'h8000; req_wdata32 = 8'h5A; req_valid32 = 1'b1;
      step();
      req_valid32 = 1'b0;
      lat = 1; csb_low = 0;
      while (!rsp_valid32 && lat < 16) begin
        if (mem_csb32 !== '1 || mem_oeb32 !== '1) csb_low++;
        step();
        lat++;
      end
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL oor_lat[%0d] got %0d exp %0d", k, lat, exp_lat); end
      checks++; if ({rsp_rdata32, rsp_err32} !== {8'h00, exp_err}) begin errors++; $display("FAIL oor_rsp[%0d] got %h/%b exp 00/%b", k, rsp_rdata32, rsp_err32, exp_err); end
      checks++; if (csb_low != 0 || mem_csb32 !== '1) begin errors++; $display("FAIL oor_csb[%0d] got %0d low cycles exp 0", k, csb_low); end
      step();
      checks++; if ({rsp_valid32, req_ready32} !== 2'b01) begin errors++; $display("FAIL oor_hs[%0d] got %b exp 01", k, {rsp_valid32, req_ready32}); end
    end
    run_txn(1'b0, 16'h8000, 8'h00, lat, rd, er, csb1, web1, oeb3, multi);
    checks++; if (rd !== exp_mem[16'h8000]) begin errors++; $display("FAIL oor_untouched got %h exp %h", rd, exp_mem[16'h8000]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_out_of_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
